// File: rtl/ex_tx_pkg.sv
// Shared types and constants for the length-prefixed frame reader and its
// output buffer.
package ex_tx_pkg;

  localparam int HDR_BYTES   = 2;
  localparam int LEN_W       = 16;
  localparam int MAX_LEN_DEF = 1500;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_HI,
    ST_HDR_LO,
    ST_PAYLOAD,
    ST_DROP
  } rd_state_e;

  // Tags the FIFO read issued last cycle, so the returning byte can be routed.
  typedef enum logic [2:0] {
    RD_NONE,
    RD_HI,
    RD_LO,
    RD_PAY,
    RD_DROP
  } rd_kind_e;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } tx_beat_t;

endpackage

// File: rtl/ex_tx_skid_buf.sv
// Two-entry output buffer. The head entry drives the output directly, so the
// presented beat only changes when it is popped or when the buffer is empty.
module ex_tx_skid_buf
  import ex_tx_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     in_valid_i,
  output logic     in_ready_o,
  input  tx_beat_t in_beat_i,
  output logic     out_valid_o,
  input  logic     out_ready_i,
  output tx_beat_t out_beat_o,
  output logic [1:0] count_o
);

  tx_beat_t   head_q, tail_q;
  logic [1:0] cnt_q;
  logic       push, pop;

  assign in_ready_o  = (cnt_q != 2'd2);
  assign out_valid_o = (cnt_q != 2'd0);
  assign out_beat_o  = head_q;
  assign count_o     = cnt_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) head_q <= in_beat_i;
          else               tail_q <= in_beat_i;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd2) head_q <= tail_q;
          cnt_q <= cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= in_beat_i;
          end else begin
            head_q <= in_beat_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_frame_reader.sv
// Pulls length-prefixed frames out of an 8-bit sync FIFO and streams the
// payload to a transmitter; oversize and empty frames are discarded.
module ex_frame_reader
  import ex_tx_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_rd_data,
  input  logic             fifo_empty,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  output logic             tx_last,
  input  logic             tx_ready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam logic [LEN_W:0] MAX_L = (LEN_W+1)'(MAX_LEN);

  rd_state_e               state_q;
  rd_kind_e                kind_q, kind_d;
  logic                    last_q;
  logic [7:0]              hi_q;
  logic [LEN_W-1:0]        rem_q;
  logic [CNT_W-1:0]        frame_cnt_q, drop_cnt_q;

  logic                    rd_en, pop, sb_ready, sb_push;
  logic [8*HDR_BYTES-1:0]  len;
  logic [1:0]              sb_cnt;
  logic [2:0]              room;
  tx_beat_t                sb_in, sb_out;

  assign len  = {hi_q, fifo_rd_data};
  assign pop  = tx_valid && tx_ready;
  // Buffer slots already claimed: stored beats plus the one in flight, less
  // the one leaving this cycle.
  assign room = {1'b0, sb_cnt} + {2'b0, kind_q == RD_PAY} - {2'b0, pop};

  always_comb begin
    rd_en  = 1'b0;
    kind_d = RD_NONE;
    case (state_q)
      ST_IDLE: begin
        rd_en  = !fifo_empty;
        kind_d = RD_HI;
      end
      ST_HDR_HI: begin
        rd_en  = !fifo_empty;
        kind_d = RD_LO;
      end
      ST_PAYLOAD: begin
        rd_en  = !fifo_empty && (room < 3'd2) && (rem_q != '0);
        kind_d = RD_PAY;
      end
      ST_DROP: begin
        rd_en  = !fifo_empty && (rem_q != '0);
        kind_d = RD_DROP;
      end
      default: ;
    endcase
    if (rst) rd_en = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      kind_q      <= RD_NONE;
      last_q      <= 1'b0;
      hi_q        <= '0;
      rem_q       <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      kind_q <= rd_en ? kind_d : RD_NONE;
      last_q <= rd_en && (rem_q == LEN_W'(1));
      if (kind_q == RD_HI) hi_q <= fifo_rd_data;
      if (pop && tx_last) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      case (state_q)
        ST_IDLE:   if (rd_en) state_q <= ST_HDR_HI;
        ST_HDR_HI: if (rd_en) state_q <= ST_HDR_LO;
        ST_HDR_LO: begin
          if (kind_q == RD_LO) begin
            rem_q <= len;
            if (len == '0) begin
              state_q    <= ST_IDLE;
              drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end else if ({1'b0, len} > MAX_L) begin
              state_q <= ST_DROP;
            end else begin
              state_q <= ST_PAYLOAD;
            end
          end
        end
        // Leaving on the final read lets IDLE fetch the next header while
        // that last byte is still in flight.
        ST_PAYLOAD, ST_DROP: begin
          if (rd_en) begin
            rem_q <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
              state_q <= ST_IDLE;
              if (state_q == ST_DROP) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sb_in   = '{data: fifo_rd_data, last: last_q};
  assign sb_push = (kind_q == RD_PAY) && sb_ready;

  ex_tx_skid_buf u_skid (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (sb_push),
    .in_ready_o (sb_ready),
    .in_beat_i  (sb_in),
    .out_valid_o(tx_valid),
    .out_ready_i(tx_ready),
    .out_beat_o (sb_out),
    .count_o    (sb_cnt)
  );

  assign fifo_rd_en = rd_en;
  assign tx_data    = sb_out.data;
  assign tx_last    = sb_out.last;
  assign busy       = (state_q != ST_IDLE) || (kind_q != RD_NONE) || (sb_cnt != 2'd0);
  assign frame_cnt  = frame_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_ex_frame_reader.sv
// Scoreboard bench for ex_frame_reader: a FIFO model feeds directed frames,
// expected beats are queued at stimulus time and popped by a tx monitor.
module tb_ex_frame_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data = 8'h00;
  logic        fifo_empty = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_last;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic [15:0] frame_cnt, drop_cnt;

  logic [7:0] fifoq[$];
  logic [8:0] expq[$];
  int         rd_cyc[$];
  int         hs_cyc[$];
  int         cyc = 0, hs_cnt = 0, n_cmp = 0, n_err = 0;
  logic       hold_empty = 1'b0;

  logic       stall_q = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  always #5 clk = ~clk;

  ex_frame_reader #(.MAX_LEN(1500), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
    .busy(busy), .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Sync FIFO model: one-cycle read latency, flag updated at the clock edge.
  always @(posedge clk) begin
    if (rst) begin
      fifoq.delete();
      fifo_rd_data <= 8'h00;
      fifo_empty   <= 1'b1;
    end else begin
      if (fifo_rd_en) begin
        n_cmp++;
        if (fifo_empty || fifoq.size() == 0) begin
          n_err++;
          $display("FAIL rd_while_empty: fifo_rd_en=1 with fifo_empty=%0b at cycle %0d", fifo_empty, cyc);
        end else begin
          fifo_rd_data <= fifoq.pop_front();
          rd_cyc.push_back(cyc);
        end
      end
      fifo_empty <= hold_empty || (fifoq.size() == 0);
    end
  end

  // tx monitor: stream stability and in-order scoreboard compare.
  always @(negedge clk) begin
    logic [8:0] e;
    if (rst) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        n_cmp++;
        if (!tx_valid || tx_data !== prev_data || tx_last !== prev_last) begin
          n_err++;
          $display("FAIL tx_stable: got v=%0b d=%02h l=%0b, required v=1 d=%02h l=%0b",
                   tx_valid, tx_data, tx_last, prev_data, prev_last);
        end
      end
      if (tx_valid && tx_ready) begin
        hs_cnt++;
        hs_cyc.push_back(cyc);
        n_cmp++;
        if (expq.size() == 0) begin
          n_err++;
          $display("FAIL tx_unexpected: got d=%02h l=%0b, required no beat", tx_data, tx_last);
        end else begin
          e = expq.pop_front();
          if (tx_data !== e[7:0] || tx_last !== e[8]) begin
            n_err++;
            $display("FAIL tx_beat: got d=%02h l=%0b, required d=%02h l=%0b",
                     tx_data, tx_last, e[7:0], e[8]);
          end
        end
      end
      stall_q   = tx_valid && !tx_ready;
      prev_data = tx_data;
      prev_last = tx_last;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    fifoq.push_back(b);
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l);
    expq.push_back({l, d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold_empty = 1'b0;
    tx_ready = 1'b1;
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    hs_cnt = 0;
    hs_cyc.delete();
    rd_cyc.delete();
  endtask

  task automatic wait_idle(input int max, input bit tog, input string nm);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(posedge clk);
      #1;
      if (tog) tx_ready = ~tx_ready;
      if (!busy && expq.size() == 0 && fifoq.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s: still busy=%0b pending_exp=%0d fifo=%0d after %0d cycles, required idle",
               nm, busy, expq.size(), fifoq.size(), max);
    end
    tx_ready = 1'b1;
  endtask

  task automatic check_zero_outputs(input string p);
    check({p, "_rd_en"},  32'(fifo_rd_en), 0);
    check({p, "_valid"},  32'(tx_valid), 0);
    check({p, "_last"},   32'(tx_last), 0);
    check({p, "_data"},   32'(tx_data), 0);
    check({p, "_busy"},   32'(busy), 0);
    check({p, "_frames"}, 32'(frame_cnt), 0);
    check({p, "_drops"},  32'(drop_cnt), 0);
  endtask

  initial begin
    // Reset state, with the FIFO model empty.
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("rst");

    // 3-byte frame at full rate.
    do_reset();
    put(8'h00); put(8'h03); put(8'hA1); put(8'hA2); put(8'hA3);
    expect_beat(8'hA1, 0); expect_beat(8'hA2, 0); expect_beat(8'hA3, 1);
    wait_idle(50, 0, "s1_done");
    check("s1_beats", hs_cyc.size(), 3);
    if (hs_cyc.size() == 3) check("s1_span", hs_cyc[2] - hs_cyc[0], 2);
    check("s1_frames", 32'(frame_cnt), 1);
    check("s1_drops", 32'(drop_cnt), 0);

    // Same frame with tx_ready toggling every cycle.
    do_reset();
    tx_ready = 1'b0;
    put(8'h00); put(8'h03); put(8'hA1); put(8'hA2); put(8'hA3);
    expect_beat(8'hA1, 0); expect_beat(8'hA2, 0); expect_beat(8'hA3, 1);
    wait_idle(100, 1, "s2_done");
    check("s2_frames", 32'(frame_cnt), 1);

    // Oversize frame (1501) is dropped, then a 1-byte frame.
    do_reset();
    put(8'h05); put(8'hDD);
    for (int i = 0; i < 1501; i++) put(i[7:0]);
    put(8'h00); put(8'h01); put(8'h5A);
    expect_beat(8'h5A, 1);
    wait_idle(3000, 0, "s3_done");
    check("s3_drops", 32'(drop_cnt), 1);
    check("s3_frames", 32'(frame_cnt), 1);

    // Zero-length frame, then a 2-byte frame.
    do_reset();
    put(8'h00); put(8'h00); put(8'h00); put(8'h02); put(8'h11); put(8'h22);
    expect_beat(8'h11, 0); expect_beat(8'h22, 1);
    wait_idle(50, 0, "s4_done");
    check("s4_drops", 32'(drop_cnt), 1);
    check("s4_frames", 32'(frame_cnt), 1);

    // Back-to-back frames: next header read right after the final payload read.
    do_reset();
    put(8'h00); put(8'h02); put(8'hD1); put(8'hD2); put(8'h00); put(8'h01); put(8'hD3);
    expect_beat(8'hD1, 0); expect_beat(8'hD2, 1); expect_beat(8'hD3, 1);
    wait_idle(50, 0, "s5_done");
    check("s5_reads", rd_cyc.size(), 7);
    if (rd_cyc.size() == 7) check("s5_b2b_gap", rd_cyc[4] - rd_cyc[3], 1);
    check("s5_frames", 32'(frame_cnt), 2);

    // Reset after 2 of 4 payload bytes.
    do_reset();
    put(8'h00); put(8'h04); put(8'hB1); put(8'hB2); put(8'hB3); put(8'hB4);
    expect_beat(8'hB1, 0); expect_beat(8'hB2, 0); expect_beat(8'hB3, 0); expect_beat(8'hB4, 1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (hs_cnt >= 2) break;
    end
    check("s6_sent_before_rst", hs_cnt, 2);
    rst = 1'b1;
    #1;
    check_zero_outputs("s6_rst");
    expq.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("s6_frames_after", 32'(frame_cnt), 0);
    check("s6_busy_after", 32'(busy), 0);
    check("s6_beats_after", hs_cnt, 2);

    // FIFO goes empty for 5 cycles mid-payload.
    do_reset();
    put(8'h00); put(8'h04); put(8'hC1); put(8'hC2); put(8'hC3); put(8'hC4);
    expect_beat(8'hC1, 0); expect_beat(8'hC2, 0); expect_beat(8'hC3, 0); expect_beat(8'hC4, 1);
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (rd_cyc.size() >= 3) break;
    end
    hold_empty = 1'b1;
    @(posedge clk);
    repeat (5) begin
      @(negedge clk);
      check("s7_empty", 32'(fifo_empty), 1);
      check("s7_rd_en", 32'(fifo_rd_en), 0);
    end
    hold_empty = 1'b0;
    wait_idle(100, 0, "s7_done");
    check("s7_reads", rd_cyc.size(), 6);
    check("s7_frames", 32'(frame_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
